sync_fifo_ctrl: RTL and testbench

SYNC_FIFO_CTRL -- requirements
Module: sync_fifo_ctrl

---
 rtl/sync_fifo_ctrl.sv | 85 ++++++++
 tb/tb_sync_fifo_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - synchronous FIFO pointer/flag controller; optional FIFO_ERR_FLAG_EN adds sticky ovfl/udfl
module sync_fifo_ctrl #(
    parameter int ASIZE     = 4,
    parameter int AFULL_TH  = 14,
    parameter int AEMPTY_TH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
`ifdef FIFO_ERR_FLAG_EN
    input  logic             err_clr,
    output logic             ovfl,
    output logic             udfl,
`endif
    output logic             mem_wen,
    output logic [ASIZE-1:0] mem_waddr,
    output logic [ASIZE-1:0] mem_raddr,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic             aempty,
    output logic [ASIZE:0]   count
);

    localparam int             DEPTH     = 1 << ASIZE;
    localparam logic [ASIZE:0] DEPTH_LV  = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] AFULL_LV  = (ASIZE+1)'(AFULL_TH);
    localparam logic [ASIZE:0] AEMPTY_LV = (ASIZE+1)'(AEMPTY_TH);
    localparam logic [ASIZE:0] ONE       = (ASIZE+1)'(1);

    logic [ASIZE:0] wptr;
    logic [ASIZE:0] rptr;
    logic [ASIZE:0] count_nxt;
    logic           wacc;
    logic           racc;

    // Accept decisions, next fill level; mem_wen is held low while reset is asserted
    always_comb begin
        wacc      = push & ~full;
        racc      = pop & ~empty;
        mem_wen   = wacc & rst_n;
        count_nxt = count + {{ASIZE{1'b0}}, wacc} - {{ASIZE{1'b0}}, racc};
    end

    assign mem_waddr = wptr[ASIZE-1:0];
    assign mem_raddr = rptr[ASIZE-1:0];

    // Pointers wrap naturally; count and flags derive from the fill level, never from pointer values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            afull  <= 1'b0;
            aempty <= 1'b1;
        end else begin
            if (wacc) wptr <= wptr + ONE;
            if (racc) rptr <= rptr + ONE;
            count  <= count_nxt;
            full   <= (count_nxt == DEPTH_LV);
            empty  <= (count_nxt == '0);
            afull  <= (count_nxt >= AFULL_LV);
            aempty <= (count_nxt <= AEMPTY_LV);
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    // Sticky overflow/underflow; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovfl <= 1'b0;
            udfl <= 1'b0;
        end else begin
            if (push && full)  ovfl <= 1'b1;
            else if (err_clr)  ovfl <= 1'b0;
            if (pop && empty)  udfl <= 1'b1;
            else if (err_clr)  udfl <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - directed self-checking bench for sync_fifo_ctrl
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       push;
    logic       pop;
    logic       mem_wen;
    logic [3:0] mem_waddr;
    logic [3:0] mem_raddr;
    logic       full;
    logic       empty;
    logic       afull;
    logic       aempty;
    logic [4:0] count;
`ifdef FIFO_ERR_FLAG_EN
    logic       err_clr;
    logic       ovfl;
    logic       udfl;
`endif

    logic [7:0] wdata;
    logic [7:0] mem [16];
    logic [7:0] q [$];
    int         mcount;
    int         vecs;
    int         errs;

    sync_fifo_ctrl #(.ASIZE(4), .AFULL_TH(14), .AEMPTY_TH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .pop       (pop),
`ifdef FIFO_ERR_FLAG_EN
        .err_clr   (err_clr),
        .ovfl      (ovfl),
        .udfl      (udfl),
`endif
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_raddr (mem_raddr),
        .full      (full),
        .empty     (empty),
        .afull     (afull),
        .aempty    (aempty),
        .count     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) mem[mem_waddr] <= wdata;
    end

    task automatic drive(input logic p, input logic r);
        push  = p;
        pop   = r;
        wdata = 8'($urandom);
        #1;
    endtask

    task automatic tick();
        logic wa;
        logic ra;
        wa = push && (mcount < 16);
        ra = pop && (mcount > 0);
        @(posedge clk);
        if (ra) void'(q.pop_front());
        if (wa) q.push_back(wdata);
        mcount = mcount + int'(wa) - int'(ra);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mcount = 0;
        q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        push  = 1'b1;
        pop   = 1'b0;
        @(posedge clk);
        #1;
        vecs++;
        if ({mem_wen, mem_waddr, mem_raddr, count, full, empty, afull, aempty} !== {1'b0, 4'd0, 4'd0, 5'd0, 4'b0101}) begin
            errs++;
            $display("FAIL reset_hold got %b exp %b",
                     {mem_wen, mem_waddr, mem_raddr, count, full, empty, afull, aempty}, {1'b0, 4'd0, 4'd0, 5'd0, 4'b0101});
        end
        push   = 1'b0;
        rst_n  = 1'b1;
        mcount = 0;
        q.delete();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        vecs++;
        if (count !== 5'd3) begin
            errs++;
            $display("FAIL pre_reset_count got %0d exp 3", count);
        end
        drive(1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        vecs++;
        if ({mem_wen, mem_waddr, mem_raddr, count, full, empty, afull, aempty} !== {1'b0, 4'd0, 4'd0, 5'd0, 4'b0101}) begin
            errs++;
            $display("FAIL reset_async got %b exp %b",
                     {mem_wen, mem_waddr, mem_raddr, count, full, empty, afull, aempty}, {1'b0, 4'd0, 4'd0, 5'd0, 4'b0101});
        end
        push = 1'b0;
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mcount = 0;
        q.delete();
        drive(1'b1, 1'b0);
        tick();
        vecs++;
        if ({count, mem_waddr, empty} !== {5'd1, 4'd1, 1'b0}) begin
            errs++;
            $display("FAIL reset_resume got %b exp %b", {count, mem_waddr, empty}, {5'd1, 4'd1, 1'b0});
        end
    endtask

    task automatic test_fill();
        logic [4:0] e;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 1'b0);
            vecs++;
            if (mem_wen !== 1'b1) begin
                errs++;
                $display("FAIL fill_wen k=%0d got %b exp 1", k, mem_wen);
            end
            tick();
            e = 5'(k);
            vecs++;
            if ({count, full, empty, afull, aempty} !== {e, e == 5'd16, e == 5'd0, e >= 5'd14, e <= 5'd2}) begin
                errs++;
                $display("FAIL fill_status k=%0d got %b exp %b", k, {count, full, empty, afull, aempty},
                         {e, e == 5'd16, e == 5'd0, e >= 5'd14, e <= 5'd2});
            end
        end
        drive(1'b1, 1'b0);
        vecs++;
        if (mem_wen !== 1'b0) begin
            errs++;
            $display("FAIL overflow_wen got %b exp 0", mem_wen);
        end
        tick();
        vecs++;
        if ({count, full, mem_waddr} !== {5'd16, 1'b1, 4'd0}) begin
            errs++;
            $display("FAIL overflow_state got %b exp %b", {count, full, mem_waddr}, {5'd16, 1'b1, 4'd0});
        end
`ifdef FIFO_ERR_FLAG_EN
        vecs++;
        if (ovfl !== 1'b1) begin
            errs++;
            $display("FAIL ovfl_set got %b exp 1", ovfl);
        end
        err_clr = 1'b1;
        drive(1'b0, 1'b0);
        tick();
        err_clr = 1'b0;
        vecs++;
        if (ovfl !== 1'b0) begin
            errs++;
            $display("FAIL ovfl_clr got %b exp 0", ovfl);
        end
`endif
    endtask

    task automatic test_drain();
        logic [4:0] e;
        logic [3:0] r0;
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b1);
            vecs++;
            if (mem[mem_raddr] !== q[0]) begin
                errs++;
                $display("FAIL drain_data k=%0d got %h exp %h", k, mem[mem_raddr], q[0]);
            end
            tick();
            e = 5'(16 - k);
            vecs++;
            if ({count, full, empty, afull, aempty} !== {e, e == 5'd16, e == 5'd0, e >= 5'd14, e <= 5'd2}) begin
                errs++;
                $display("FAIL drain_status k=%0d got %b exp %b", k, {count, full, empty, afull, aempty},
                         {e, e == 5'd16, e == 5'd0, e >= 5'd14, e <= 5'd2});
            end
        end
        drive(1'b0, 1'b1);
        r0 = mem_raddr;
        tick();
        vecs++;
        if ({mem_raddr, count, empty} !== {r0, 5'd0, 1'b1}) begin
            errs++;
            $display("FAIL underflow_state got %b exp %b", {mem_raddr, count, empty}, {r0, 5'd0, 1'b1});
        end
`ifdef FIFO_ERR_FLAG_EN
        vecs++;
        if (udfl !== 1'b1) begin
            errs++;
            $display("FAIL udfl_set got %b exp 1", udfl);
        end
        err_clr = 1'b1;
        drive(1'b0, 1'b1);
        tick();
        err_clr = 1'b0;
        vecs++;
        if (udfl !== 1'b1) begin
            errs++;
            $display("FAIL udfl_set_wins got %b exp 1", udfl);
        end
`endif
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1);
        vecs++;
        if (mem[mem_raddr] !== q[0]) begin
            errs++;
            $display("FAIL simul_mid_data got %h exp %h", mem[mem_raddr], q[0]);
        end
        tick();
        vecs++;
        if ({count, mem_waddr, mem_raddr} !== {5'd5, 4'd6, 4'd1}) begin
            errs++;
            $display("FAIL simul_mid got %b exp %b", {count, mem_waddr, mem_raddr}, {5'd5, 4'd6, 4'd1});
        end
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b0);
            tick();
        end
        drive(1'b1, 1'b1);
        vecs++;
        if ({mem_wen, full} !== 2'b01) begin
            errs++;
            $display("FAIL simul_full_wen got %b exp 01", {mem_wen, full});
        end
        tick();
        vecs++;
        if ({count, full, afull} !== {5'd15, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL simul_full got %b exp %b", {count, full, afull}, {5'd15, 1'b0, 1'b1});
        end
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b1);
            vecs++;
            if (mem[mem_raddr] !== q[0]) begin
                errs++;
                $display("FAIL simul_drain_data i=%0d got %h exp %h", i, mem[mem_raddr], q[0]);
            end
            tick();
        end
        drive(1'b1, 1'b1);
        vecs++;
        if ({mem_wen, empty} !== 2'b11) begin
            errs++;
            $display("FAIL simul_empty_wen got %b exp 11", {mem_wen, empty});
        end
        tick();
        vecs++;
        if ({count, empty, aempty} !== {5'd1, 1'b0, 1'b1}) begin
            errs++;
            $display("FAIL simul_empty got %b exp %b", {count, empty, aempty}, {5'd1, 1'b0, 1'b1});
        end
        vecs++;
        if (mem[mem_raddr] !== q[0]) begin
            errs++;
            $display("FAIL simul_empty_fwft got %h exp %h", mem[mem_raddr], q[0]);
        end
    endtask

    task automatic test_wrap();
        int over;
        over = 0;
        do_reset();
        drive(1'b1, 1'b0);
        tick();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1);
            vecs++;
            if (mem[mem_raddr] !== q[0]) begin
                errs++;
                $display("FAIL wrap_data i=%0d got %h exp %h", i, mem[mem_raddr], q[0]);
            end
            tick();
            if (count !== 5'd1 || empty !== 1'b0) over++;
        end
        vecs++;
        if (over != 0) begin
            errs++;
            $display("FAIL wrap_count got %0d bad cycles exp 0", over);
        end
        vecs++;
        if ({mem_waddr, mem_raddr} !== {4'd9, 4'd8}) begin
            errs++;
            $display("FAIL wrap_addr got %b exp %b", {mem_waddr, mem_raddr}, {4'd9, 4'd8});
        end
        drive(1'b0, 1'b1);
        vecs++;
        if (mem[mem_raddr] !== q[0]) begin
            errs++;
            $display("FAIL wrap_last_data got %h exp %h", mem[mem_raddr], q[0]);
        end
        tick();
        vecs++;
        if ({count, empty, aempty, full, afull} !== {5'd0, 4'b1100}) begin
            errs++;
            $display("FAIL wrap_final got %b exp %b", {count, empty, aempty, full, afull}, {5'd0, 4'b1100});
        end
    endtask

    initial begin
        vecs   = 0;
        errs   = 0;
        mcount = 0;
        push   = 1'b0;
        pop    = 1'b0;
        wdata  = 8'h00;
`ifdef FIFO_ERR_FLAG_EN
        err_clr = 1'b0;
`endif
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
